// File: rtl/hard_mem_1rw_byte_mask_client_pkg.sv
// hard_mem_1rw_byte_mask_client_pkg: shared state, request and buffer definitions for the SRAM client.
package hard_mem_1rw_byte_mask_client_pkg;
  localparam int resp_depth_lp = 2;
  localparam int width_lp = 64;
  localparam int els_lp = 512;
  typedef enum logic {e_client_init, e_client_ready} client_state_e;
  typedef struct packed {
    logic w;
    logic [$clog2(els_lp)-1:0] addr;
    logic [width_lp-1:0] data;
    logic [(width_lp>>3)-1:0] write_mask;
  } client_req_s;
endpackage

// File: rtl/hard_mem_1rw_byte_mask_client_if.sv
// hard_mem_1rw_byte_mask_client_if: request, response and SRAM-macro signals of the client.
interface hard_mem_1rw_byte_mask_client_if #(parameter int width_p = 64, parameter int els_p = 512);
  localparam int addr_width_lp = $clog2(els_p);
  localparam int write_mask_width_lp = width_p >> 3;
  logic req_v, req_ready, req_w;
  logic [addr_width_lp-1:0] req_addr;
  logic [width_p-1:0] req_data;
  logic [write_mask_width_lp-1:0] req_mask;
  logic resp_v, resp_yumi;
  logic [width_p-1:0] resp_data;
  logic mem_v, mem_w;
  logic [addr_width_lp-1:0] mem_addr;
  logic [width_p-1:0] mem_wdata, mem_rdata;
  logic [write_mask_width_lp-1:0] mem_mask;
  modport master (
    output req_v, req_w, req_addr, req_data, req_mask, resp_yumi, mem_rdata,
    input req_ready, resp_v, resp_data, mem_v, mem_w, mem_addr, mem_wdata, mem_mask
  );
  modport slave (
    input req_v, req_w, req_addr, req_data, req_mask, resp_yumi, mem_rdata,
    output req_ready, resp_v, resp_data, mem_v, mem_w, mem_addr, mem_wdata, mem_mask
  );
endinterface

// File: rtl/hard_mem_1rw_client_resp_fifo.sv
// hard_mem_1rw_client_resp_fifo: 2-entry read-response buffer with occupancy count.
module hard_mem_1rw_client_resp_fifo #(parameter int width_p = 64) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enq,
  input  logic deq,
  input  logic [width_p-1:0] data,
  output logic [width_p-1:0] head,
  output logic [1:0] count
);
  logic [width_p-1:0] slots [2];
  logic rd_ptr, wr_ptr;
  always_ff @(posedge clk_i) begin
    rd_ptr <= reset_i ? 1'b0 : rd_ptr ^ deq;
    wr_ptr <= reset_i ? 1'b0 : wr_ptr ^ enq;
    count <= reset_i ? 2'd0 : count + {1'b0, enq} - {1'b0, deq};
  end
  always_ff @(posedge clk_i)
    if (enq) slots[wr_ptr] <= data;
  assign head = slots[rd_ptr];
endmodule

// File: rtl/hard_mem_1rw_byte_mask_client.sv
// hard_mem_1rw_byte_mask_client: request stream to 1RW byte-masked SRAM strobes with buffered read responses.
// HARD_MEM_CLIENT_INIT_EN adds a zero-fill pass over the whole memory after reset.
module hard_mem_1rw_byte_mask_client
  import hard_mem_1rw_byte_mask_client_pkg::*;
#(parameter int width_p = 64, parameter int els_p = 512) (
  input logic clk_i,
  input logic reset_i,
  hard_mem_1rw_byte_mask_client_if.slave bus
);
  localparam int addr_width_lp = $clog2(els_p);
  client_state_e state, state_n;
  logic inflight_r, ready, accept, enq, deq, init;
  logic [1:0] count;
  logic [width_p-1:0] head;
  logic [addr_width_lp-1:0] init_cnt;
`ifdef HARD_MEM_CLIENT_INIT_EN
  localparam client_state_e reset_state_lp = e_client_init;
  logic init_last;
  assign init = state == e_client_init;
  assign init_last = init_cnt == addr_width_lp'(els_p - 1);
  always_ff @(posedge clk_i)
    init_cnt <= (reset_i || !init || init_last) ? '0 : init_cnt + 1'b1;
  assign state_n = (init && init_last) ? e_client_ready : state;
`else
  localparam client_state_e reset_state_lp = e_client_ready;
  assign init = 1'b0;
  assign init_cnt = '0;
  assign state_n = state;
`endif
  always_ff @(posedge clk_i) begin
    state <= reset_i ? reset_state_lp : state_n;
    inflight_r <= ~reset_i & accept & ~bus.req_w;
  end
  // A read is only accepted when a buffer slot is guaranteed for its response
  assign ready = ~reset_i & (state == e_client_ready) & (({1'b0, count} + {2'b0, inflight_r}) < 3'(resp_depth_lp));
  assign accept = bus.req_v & ready;
  assign deq = bus.resp_yumi & (count != 2'd0);
  assign enq = inflight_r & ~((count == 2'd0) & bus.resp_yumi);
  hard_mem_1rw_client_resp_fifo #(.width_p(width_p)) fifo (
    .clk_i(clk_i), .reset_i(reset_i), .enq(enq), .deq(deq),
    .data(bus.mem_rdata), .head(head), .count(count)
  );
  assign bus.req_ready = ready;
  assign bus.mem_v = ~reset_i & (init | accept);
  assign bus.mem_w = init | bus.req_w;
  assign bus.mem_addr = init ? init_cnt : bus.req_addr;
  assign bus.mem_wdata = init ? '0 : bus.req_data;
  assign bus.mem_mask = init ? '1 : bus.req_mask;
  assign bus.resp_v = ~reset_i & ((count != 2'd0) | inflight_r);
  assign bus.resp_data = (count != 2'd0) ? head : bus.mem_rdata;
  assert property (@(posedge clk_i) disable iff (reset_i) bus.resp_yumi |-> bus.resp_v);
endmodule
